// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared FSM state encoding and default operand width
package shift_add_mult_pkg;
  localparam int DATA_SIZE_DEF = 8;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, CALC, DONE} state_t;
endpackage

// File: rtl/mult_datapath.sv
// mult_datapath: accumulator, adder and shifter for the shift-add multiplier
module mult_datapath
  import shift_add_mult_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   calc_i,
  input  logic                   store_i,
  input  logic [DATA_SIZE-1:0]   a_i,
  input  logic [DATA_SIZE-1:0]   b_i,
  output logic [2*DATA_SIZE-1:0] product_o
);
  logic [DATA_SIZE-1:0]   mcand_q, mcand_d;
  logic [2*DATA_SIZE:0]   acc_q, acc_d;
  logic [2*DATA_SIZE-1:0] product_q, product_d;
  logic [DATA_SIZE:0]     sum;
  // Upper half plus the carry bit; the extra top bit keeps the add's carry out
  always_comb begin
    sum       = acc_q[2*DATA_SIZE:DATA_SIZE] + {1'b0, acc_q[0] ? mcand_q : '0};
    acc_d     = load_i ? {{(DATA_SIZE+1){1'b0}}, b_i} :
                calc_i ? {1'b0, sum, acc_q[DATA_SIZE-1:1]} : acc_q;
    mcand_d   = load_i ? a_i : mcand_q;
    product_d = store_i ? acc_q[2*DATA_SIZE-1:0] : product_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end
  assign product_o = product_q;
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned multiplier, FSM and iteration counter
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   unload_o,
  input  logic [DATA_SIZE-1:0]   a_i,
  input  logic [DATA_SIZE-1:0]   b_i,
  output logic [2*DATA_SIZE-1:0] product_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int CW = $clog2(DATA_SIZE + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last, load, calc, store;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // CALC spends one extra cycle once the count reaches DATA_SIZE to store the product
  always_comb begin
    last = cnt_q == CW'(DATA_SIZE);
    unique case (state_q)
      IDLE:    state_d = start_i ? FETCH : IDLE;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = CALC;
      CALC:    state_d = last ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_q == LOAD ? '0 : calc ? cnt_q + CW'(1) : cnt_q;
  end
  always_comb begin
    load     = state_q == LOAD;
    calc     = state_q == CALC && !last;
    store    = state_q == CALC && last;
    unload_o = !rst_i && state_q == FETCH;
    busy_o   = !rst_i && state_q != IDLE;
    done_o   = !rst_i && state_q == DONE;
  end
  mult_datapath #(.DATA_SIZE(DATA_SIZE)) u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .calc_i    (calc),
    .store_i   (store),
    .a_i       (a_i),
    .b_i       (b_i),
    .product_o (product_o)
  );
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: randomized and directed checks against an arithmetic reference
module tb_shift_add_mult;
  localparam int N = 8;
  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           start_i = 1'b0;
  logic           unload_o, busy_o, done_o;
  logic [N-1:0]   a_i = '0, b_i = '0;
  logic [2*N-1:0] product_o;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  shift_add_mult #(.DATA_SIZE(N)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .unload_o  (unload_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .product_o (product_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // One operation launched by a single start pulse; optional stray start pulse and reset edge
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int pulse_e, input int rst_e);
    int u_cnt = 0, u_e = -1, d_cnt = 0, d_e = -1;
    logic [2*N-1:0] p_done = '0, exp;
    exp = rst_e >= 0 ? '0 : (2*N)'(a) * (2*N)'(b);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start_i = 1'b0;
      if (e == pulse_e) start_i = 1'b1;
      if (e == pulse_e + 1 && pulse_e >= 0) start_i = 1'b0;
      if (e == rst_e + 1 && rst_e >= 0) begin
        rst_i = 1'b0;
        check("rst_idle_busy", busy_o, 0);
        check("rst_product", product_o, 0);
      end
      if (e == rst_e) begin
        rst_i = 1'b1;
        #1;
        check("rst_gate_busy", busy_o, 0);
        check("rst_gate_done", done_o, 0);
      end
      if (unload_o) begin u_cnt++; u_e = e; end
      if (done_o) begin d_cnt++; d_e = e; p_done = product_o; end
    end
    check("unload_count", u_cnt, 1);
    check("unload_edge", u_e, 0);
    if (rst_e >= 0) check("abort_done_count", d_cnt, 0);
    else begin
      check("done_count", d_cnt, 1);
      check("done_edge", d_e, N + 3);
      check("product_at_done", p_done, exp);
    end
    check("product_held", product_o, exp);
    check("busy_after", busy_o, 0);
  endtask
  initial begin
    int d1, d2;
    logic [2*N-1:0] p1, p2;
    start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", product_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_unload", unload_o, 0);
    rst_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", busy_o, 0);
    run_op(8'd13, 8'd11, -1, -1);
    run_op(8'd255, 8'd255, -1, -1);
    run_op(8'd0, 8'd200, -1, -1);
    run_op(8'd200, 8'd0, -1, -1);
    run_op(8'd1, 8'd255, -1, -1);
    run_op(8'd57, 8'd91, 5, -1);
    run_op(8'd99, 8'd77, -1, 5);
    run_op(8'd6, 8'd7, -1, -1);
    for (int i = 0; i < 12; i++)
      run_op(N'($urandom), N'($urandom), -1, -1);
    // Continuous start: second operation picks up new operands after the first completes
    d1 = -1; d2 = -1; p1 = '0; p2 = '0;
    a_i = 8'd3;
    b_i = 8'd5;
    start_i = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done_o && d1 < 0) begin
        d1 = e; p1 = product_o; a_i = 8'd7; b_i = 8'd9;
      end else if (done_o && d2 < 0) begin
        d2 = e; p2 = product_o; start_i = 1'b0;
      end
    end
    check("b2b_first_edge", d1, N + 3);
    check("b2b_cycles_between", d2 - d1 - 1, 12);
    check("b2b_first_product", p1, 15);
    check("b2b_second_product", p2, 63);
    check("b2b_busy_after", busy_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk_i.
REQ-002 The block SHALL have parameter DATA_SIZE, default 8, giving the operand width in bits.
REQ-003 Port clk_i, input, 1 bit: clock.
REQ-004 Port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 Port start_i, input, 1 bit: request one multiplication.
REQ-006 Port unload_o, output, 1 bit: operand fetch strobe to the upstream A and B operand registers (drives their unload_i).
REQ-007 Port a_i, input, DATA_SIZE bits: multiplicand from the operand A register.
REQ-008 Port b_i, input, DATA_SIZE bits: multiplier from the operand B register.
REQ-009 Port product_o, output, 2*DATA_SIZE bits: unsigned product, registered.
REQ-010 Port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, FETCH, LOAD, CALC and DONE.
REQ-013 In IDLE, start_i=1 at an edge SHALL move the FSM to FETCH; start_i=0 SHALL keep it in IDLE.
REQ-014 In FETCH, unload_o SHALL be 1 for exactly that one cycle, and the next edge SHALL move the FSM to LOAD; unload_o SHALL be 0 in every other state.
REQ-015 At the edge leaving LOAD, the block SHALL capture a_i and b_i, clear the accumulator, clear the iteration counter, and move to CALC.
REQ-016 In CALC, each edge SHALL perform one iteration: if the current multiplier LSB is 1, add the multiplicand to the upper half of the 2*DATA_SIZE+1-bit accumulator; then shift the accumulator right by 1.
REQ-017 The carry out of the add SHALL be held in accumulator bit 2*DATA_SIZE and SHALL never be lost.
REQ-018 After exactly DATA_SIZE CALC iterations, the FSM SHALL load product_o with the accumulator's low 2*DATA_SIZE bits and move to DONE.
REQ-019 In DONE, done_o SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-020 done_o SHALL be high during the cycle that follows edge DATA_SIZE+3, counting the edge that sampled start_i as edge 0; with DATA_SIZE=8 this is edge 11.
REQ-021 product_o SHALL hold its value from DONE until the next DONE.
REQ-022 start_i SHALL be ignored outside IDLE; there SHALL be no queuing.
REQ-023 A start_i held high continuously SHALL begin a new operation in the cycle after DONE's return to IDLE, giving back-to-back operations with one IDLE cycle between them.
REQ-024 The arithmetic SHALL be unsigned and exact for every operand pair, including 0 and 2^DATA_SIZE-1.

Reset
REQ-025 When rst_i=1 at an edge, the FSM SHALL go to IDLE and product_o, the accumulator and the counter SHALL clear to 0.
REQ-026 With reset asserted, done_o, busy_o and unload_o SHALL be 0 regardless of current state; reset SHALL take priority over start_i.
REQ-027 Reset asserted mid-operation (FETCH, LOAD or CALC) SHALL abort the operation with no done_o pulse, and product_o SHALL be 0.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration and the DATA_SIZE default.
REQ-029 A counter width of $clog2(DATA_SIZE+1) SHALL be derived locally.
REQ-030 One sub-module, mult_datapath, SHALL contain the accumulator, adder and shifter; the top level SHALL contain the FSM and the counter.
REQ-031 The operand registers themselves SHALL remain outside this block.

Verification
REQ-032 Bench SHALL drive a_i=13, b_i=11, one start_i pulse -> unload_o high one cycle, done_o high one cycle at edge 11, product_o=143, busy_o low afterward.
REQ-033 Bench SHALL drive a_i=255, b_i=255 -> product_o=65025, proving the carry is retained.
REQ-034 Bench SHALL drive a_i=0, b_i=200, then a_i=200, b_i=0 -> product_o=0 both times, done_o timing unchanged.
REQ-035 Bench SHALL pulse start_i again during CALC -> no effect, exactly one done_o pulse, result unchanged.
REQ-036 Bench SHALL hold start_i high continuously with operand pairs 3x5 then 7x9 -> done pulses 12 cycles apart, product_o=15 then 63.
REQ-037 Bench SHALL assert rst_i for one cycle at the 4th CALC cycle -> IDLE next cycle, product_o=0, no done_o pulse, and a following 6x7 operation gives 42.
